// File: rtl/div_sequencer.sv
// div_sequencer - launches the iterative divider, waits for its result and holds HI/LO.
// Every output is a flop loaded from a decode of the next state, so pulses line up with state cycles.
module div_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_control,
  input  logic             div_stop,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] hi_div,
  input  logic [WIDTH-1:0] lo_div,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic             timeout_err,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_CHECK, S_WAIT, S_DONE, S_ERR_Z, S_ERR_T
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_control_q, div_control_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zexc_q, zexc_d;
  logic             terr_q, terr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    hi_d    = hi_we ? hi_wdata : hi_q;
    lo_d    = lo_we ? lo_wdata : lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_a_d = op_a;
          div_b_d = op_b;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK:  state_d = div_zero ? S_ERR_Z : S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A result commit overrides any mthi/mtlo landing on the same edge.
        if (div_stop) begin
          hi_d    = hi_div;
          lo_d    = lo_div;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR_T;
        end
      end
      default:  state_d = S_IDLE;
    endcase

    div_control_d = (state_d == S_LAUNCH);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    zexc_d        = (state_d == S_ERR_Z);
    terr_d        = (state_d == S_ERR_T);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      div_control_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      zexc_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      div_control_q <= div_control_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      zexc_q        <= zexc_d;
      terr_q        <= terr_d;
    end
  end

  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign div_control  = div_control_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero_exc = zexc_q;
  assign timeout_err  = terr_q;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule
